hps_reset_sequencer: RTL
========================

HPS_RESET_SEQUENCER -- requirements
Module: hps_reset_sequencer

Interface
REQ-001 Parameter N_CH, default 3: number of reset-request channels; channel 0 has highest priority.
REQ-002 Parameter CNT_W, default 8: width of each per-channel pulse-length field and of the internal counters.
REQ-003 Parameter SYNC_STAGES, default 2, legal 2..4: flops in each input synchroniser.
REQ-004 Parameter EDGE_TYPE, default 1: trigger edge; 0 = falling, 1 = rising, 2 = either.
REQ-005 Parameter HOLDOFF, default 16, legal 1..2^CNT_W-1: post-pulse cycles during which the channel ignores edges.
REQ-006 Port clk, input, 1: single clock for all logic.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port enable, input, 1: 1 = accept new edges; 0 = ignore new edges, but pulses already in progress complete.
REQ-009 Port signal_in, input, N_CH: asynchronous request inputs.
REQ-010 Port pulse_len, input, N_CH*CNT_W: per-channel pulse length; channel i uses bits [i*CNT_W +: CNT_W].
REQ-011 Port pulse_out, output, N_CH: registered, active-high reset-request pulses.
REQ-012 Port busy, output, N_CH: registered; 1 while the channel is in PULSE or HOLD.
REQ-013 Port any_pulse, output, 1: registered OR of all pulse_out bits.

Function
REQ-014 Each signal_in bit shall pass through SYNC_STAGES flops, followed by one delay flop (prev); edge detection compares the last synchroniser stage against prev, per EDGE_TYPE.
REQ-015 After reset deasserts, edge detection shall be masked for SYNC_STAGES+1 cycles (warm-up counter), so a level held across reset generates no pulse.
REQ-016 Each channel shall implement the states IDLE, PULSE and HOLD.
REQ-017 IDLE -> PULSE when an accepted edge occurs: edge detected, enable=1, warm-up done, and not suppressed by a higher-priority channel.
REQ-018 On entry to PULSE, the counter shall load L = pulse_len field, with a value of 0 treated as 1; pulse_out shall be 1 for exactly L cycles.
REQ-019 PULSE -> HOLD when the count expires; HOLD shall last HOLDOFF cycles, then return to IDLE.
REQ-020 Edges arriving in PULSE or HOLD shall be discarded, not queued; there is no retrigger.
REQ-021 pulse_len shall be sampled only at IDLE->PULSE; changes during PULSE have no effect.
REQ-022 Latency: a signal_in transition captured at clock edge E0 shall produce pulse_out=1 after edge E0+SYNC_STAGES.
REQ-023 Priority preemption: an accepted edge on channel i shall, at the same clock edge, force every channel j>i that is in PULSE to HOLD (pulse_out[j]=0 next cycle, HOLD counter reloaded).
REQ-024 The same accepted edge shall discard any simultaneous edge on every channel j>i.
REQ-025 Simultaneous edges on several IDLE channels: only the lowest index shall enter PULSE; the higher-index channels stay in IDLE and their edges are lost.
REQ-026 Channels in HOLD are unaffected by preemption.
REQ-027 busy[i] = 1 in PULSE or HOLD; any_pulse shall be registered from the next-state pulse_out values, with no extra latency.
REQ-028 All counters shall be CNT_W bits, count down, and never wrap (saturate at 0).

Reset
REQ-029 While reset=1 at a clock edge: all channels go to IDLE; pulse_out, busy and any_pulse = 0; synchronisers, prev and counters = 0; warm-up counter reloaded.
REQ-030 Reset asserted mid-PULSE shall drop pulse_out on the next clock edge, with no completion of the pulse.

Verification
REQ-031 Defaults, pulse_len ch1 = 6, rising edge on signal_in[1] at edge E0 -> pulse_out[1]=1 for edges E0+2..E0+7, then busy[1]=1 for 16 more cycles.
REQ-032 pulse_len ch2 = 0, rising edge -> exactly one cycle of pulse_out[2]=1.
REQ-033 ch2 in PULSE (len 32), edge on ch0 (len 4) -> pulse_out[2]=0 and pulse_out[0]=1 at the same edge; ch2 busy for 16 more cycles.
REQ-034 Simultaneous edges on ch0 and ch1 -> only pulse_out[0] asserts; a second ch1 edge during ch0's HOLD -> ch1 pulses normally.
REQ-035 signal_in[0] held high through reset release -> no pulse; enable=0 during an edge -> no pulse; enable dropped mid-pulse -> the pulse completes at full length.
REQ-036 Reset asserted in cycle 3 of an 8-cycle pulse -> pulse_out=0 at the next edge; all outputs 0; no pulse after release.

Source files
------------

// File: rtl/hps_reset_sequencer.sv
// Purpose: turns synchronised edges on N_CH request lines into prioritised, fixed-length reset pulses.
// Latency: a request captured at edge E0 drives pulse_out high after edge E0+SYNC_STAGES.
// Backpressure: none; edges arriving while a channel is busy, disabled or preempted are dropped.
module hps_reset_sequencer #(
    parameter int N_CH        = 3,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 1,
    parameter int HOLDOFF     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_CH-1:0]         signal_in,
    input  logic [N_CH*CNT_W-1:0]   pulse_len,
    output logic [N_CH-1:0]         pulse_out,
    output logic [N_CH-1:0]         busy,
    output logic                    any_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] WARM_INIT = CNT_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
    logic [N_CH-1:0]                  prev_q, prev_d;
    logic [CNT_W-1:0]                 warm_q, warm_d;
    state_t                           state_q [N_CH];
    state_t                           state_d [N_CH];
    logic [CNT_W-1:0]                 cnt_q   [N_CH];
    logic [CNT_W-1:0]                 cnt_d   [N_CH];
    logic [N_CH-1:0]                  pulse_q, pulse_d;
    logic [N_CH-1:0]                  busy_q, busy_d;
    logic                             any_q, any_d;

    logic [N_CH-1:0]                  sync_last;
    logic [N_CH-1:0]                  edge_det;
    logic                             warm_done;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_q == '0);

    // Synchroniser shift, edge-history flop and post-reset warm-up countdown.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], signal_in};
        prev_d = sync_last;
        warm_d = warm_done ? warm_q : warm_q - CNT_ONE;
    end

    // Edge detector between the last synchroniser stage and its delayed copy.
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = ~sync_last & prev_q;
            1:       edge_det = sync_last & ~prev_q;
            default: edge_det = sync_last ^ prev_q;
        endcase
    end

    // Per-channel next state: lower index wins, and its accepted edge preempts running pulses above it.
    always_comb begin : ch_next
        logic             taken;
        logic             acc;
        logic [CNT_W-1:0] len_sel;
        taken   = 1'b0;
        acc     = 1'b0;
        len_sel = '0;
        pulse_d = '0;
        busy_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            len_sel    = pulse_len[i*CNT_W +: CNT_W];
            acc        = edge_det[i] && enable && warm_done &&
                         (state_q[i] == ST_IDLE) && !taken;
            case (state_q[i])
                ST_IDLE: begin
                    if (acc) begin
                        state_d[i] = ST_PULSE;
                        cnt_d[i]   = (len_sel == '0) ? CNT_ONE : len_sel;
                    end
                end
                ST_PULSE: begin
                    if (taken || cnt_q[i] <= CNT_ONE) begin
                        state_d[i] = ST_HOLD;
                        cnt_d[i]   = HOLD_LOAD;
                    end else begin
                        cnt_d[i]   = cnt_q[i] - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q[i] <= CNT_ONE) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] - CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            taken      = taken | acc;
            pulse_d[i] = (state_d[i] == ST_PULSE);
            busy_d[i]  = (state_d[i] != ST_IDLE);
        end
        any_d = |pulse_d;
    end

    // State, counters and registered outputs; synchronous reset clears everything and rearms warm-up.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= '0;
            warm_q  <= WARM_INIT;
            pulse_q <= '0;
            busy_q  <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            warm_q  <= warm_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            any_q   <= any_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign any_pulse = any_q;

endmodule
